// File: rtl/fifo_uart_tx_pkg.sv
// rtl/fifo_uart_tx_pkg.sv - shared types and constants for the FIFO-fed UART transmitter
package fifo_uart_tx_pkg;

    localparam int DEFAULT_DIV_W = 12;

    localparam logic [1:0] PRI_NONE = 2'd0;
    localparam logic [1:0] PRI_EVEN = 2'd1;
    localparam logic [1:0] PRI_ODD  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } state_t;

    function automatic logic has_parity(input logic [1:0] mode);
        return (mode == PRI_EVEN) || (mode == PRI_ODD);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - loadable bit-period down-counter, flags the last clock of a bit
module uart_bit_timer
    import fifo_uart_tx_pkg::*;
#(
    parameter int DIV_W = DEFAULT_DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_load_val,
    output logic             o_bit_end
);

    logic [DIV_W-1:0] r_count;

    // Holds at zero instead of wrapping; the FSM always reloads at bit end.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_bit_end = (r_count == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops bytes from a fast-mode FIFO and shifts them out as UART frames
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DIV_W = DEFAULT_DIV_W,
    parameter int W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_tx_en,
    input  logic [DIV_W-1:0] cfg_baud_div,
    input  logic [1:0]       cfg_pri_mod,
    input  logic             cfg_two_stop,
    input  logic             fifo_empty,
    input  logic [W-1:0]     fifo_rd_data,
    output logic             fifo_rd_en,
    output logic             txd,
    output logic             tx_busy,
    output logic             tx_done
);

    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [W-1:0]     r_shift;
    logic [W-1:0]     r_data;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_pri;
    logic             r_two_stop;
    logic [IDX_W-1:0] r_bit_idx;
    logic             r_txd;

    logic             w_bit_end;
    logic             w_load;
    logic [DIV_W-1:0] w_load_val;
    logic             w_pop;
    logic             w_can_pop;
    logic             w_frame_end;
    logic             w_shift;
    logic             w_txd_nxt;
    logic             w_parity;

    uart_bit_timer #(.DIV_W(DIV_W)) u_bit_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_bit_end  (w_bit_end)
    );

    assign w_can_pop = cfg_tx_en & ~fifo_empty & ~reset;
    assign w_parity  = (r_pri == PRI_ODD) ? ~^r_data : ^r_data;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = r_div;
        w_pop       = 1'b0;
        w_frame_end = 1'b0;
        w_shift     = 1'b0;
        w_txd_nxt   = r_txd;

        case (r_state)
            ST_IDLE: begin
                w_txd_nxt = 1'b1;
                if (w_can_pop) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_START;
                    w_txd_nxt   = 1'b0;
                    w_load      = 1'b1;
                    w_load_val  = cfg_baud_div;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_DATA;
                    w_txd_nxt   = r_shift[0];
                    w_load      = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_load = 1'b1;
                    if (r_bit_idx == LAST_IDX) begin
                        if (has_parity(r_pri)) begin
                            w_state_nxt = ST_PARITY;
                            w_txd_nxt   = w_parity;
                        end else begin
                            w_state_nxt = ST_STOP1;
                            w_txd_nxt   = 1'b1;
                        end
                    end else begin
                        w_shift   = 1'b1;
                        w_txd_nxt = r_shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_STOP1;
                    w_txd_nxt   = 1'b1;
                    w_load      = 1'b1;
                end
            end
            ST_STOP1: begin
                if (w_bit_end) begin
                    if (r_two_stop) begin
                        w_state_nxt = ST_STOP2;
                        w_load      = 1'b1;
                    end else begin
                        w_frame_end = 1'b1;
                    end
                end
            end
            ST_STOP2: begin
                if (w_bit_end) begin
                    w_frame_end = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_txd_nxt   = 1'b1;
            end
        endcase

        // A waiting byte is popped in the last stop clock so the next start bit follows directly.
        if (w_frame_end) begin
            if (w_can_pop) begin
                w_pop       = 1'b1;
                w_state_nxt = ST_START;
                w_txd_nxt   = 1'b0;
                w_load      = 1'b1;
                w_load_val  = cfg_baud_div;
            end else begin
                w_state_nxt = ST_IDLE;
                w_txd_nxt   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_data     <= '0;
            r_div      <= '0;
            r_pri      <= PRI_NONE;
            r_two_stop <= 1'b0;
            r_bit_idx  <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_txd   <= w_txd_nxt;
            if (w_pop) begin
                r_shift    <= fifo_rd_data;
                r_data     <= fifo_rd_data;
                r_div      <= cfg_baud_div;
                r_pri      <= cfg_pri_mod;
                r_two_stop <= cfg_two_stop;
                r_bit_idx  <= '0;
            end else if (w_shift) begin
                r_shift   <= r_shift >> 1;
                r_bit_idx <= r_bit_idx + 1'b1;
            end
        end
    end

    assign fifo_rd_en = w_pop;
    assign txd        = r_txd;
    assign tx_busy    = (r_state != ST_IDLE);
    assign tx_done    = w_frame_end & ~reset;

endmodule
